// File: rtl/asym_bram_fifo_ctrl.sv
// asym_bram_fifo_ctrl
// FIFO controller for an external asymmetric BRAM with a narrow write port and
// a wide, 1-cycle registered read port. Narrow words stream in on s_*, wide
// words stream out on m_* through a 2-entry output buffer.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high; valid never waits on ready, and m_data is held while
// m_valid && !m_ready.
//
// Optional feature: define ASYM_FIFO_FLUSH_EN to add flush/flush_done and the
// RUN/PAD state machine that zero-pads a partial wide word.
module asym_bram_fifo_ctrl #(
    parameter int WRITE_DATA_WIDTH = 16,
    parameter int READ_DATA_WIDTH  = 32,
    parameter int WRITE_ADDR_WIDTH = 11,
    parameter int READ_ADDR_WIDTH  = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [WRITE_DATA_WIDTH-1:0]   s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [READ_DATA_WIDTH-1:0]    m_data,
    output logic [WRITE_ADDR_WIDTH:0]     level,
    output logic                          ram_wce,
    output logic [WRITE_ADDR_WIDTH-1:0]   ram_wa,
    output logic [WRITE_DATA_WIDTH-1:0]   ram_wd,
    output logic                          ram_rce,
    output logic [READ_ADDR_WIDTH-1:0]    ram_ra,
    input  logic [READ_DATA_WIDTH-1:0]    ram_rq
`ifdef ASYM_FIFO_FLUSH_EN
    ,
    input  logic                          flush,
    output logic                          flush_done
`endif
);

    localparam int WDW   = WRITE_DATA_WIDTH;
    localparam int RDW   = READ_DATA_WIDTH;
    localparam int WAW   = WRITE_ADDR_WIDTH;
    localparam int RAW   = READ_ADDR_WIDTH;
    // Narrow words per wide word (1, 2 or 4); WAW - RAW is its log2.
    localparam int RATIO = RDW / WDW;
    localparam int LOG2R = WAW - RAW;
    localparam logic [WAW:0] DEPTH_L = {1'b1, {WAW{1'b0}}};

    logic [WAW-1:0] wptr_q, wptr_d;
    logic [RAW-1:0] rptr_q, rptr_d;
    logic [WAW:0]   level_q, level_d;
    logic           inflight_q, inflight_d;
    logic [1:0]     buf_cnt_q, buf_cnt_d;
    logic [RDW-1:0] buf0_q, buf0_d;
    logic [RDW-1:0] buf1_q, buf1_d;

    logic           has_space;
    logic           in_run;
    logic           pad_wr;
    logic           wr_en;
    logic           pop;
    logic           issue;
    logic [WAW-1:0] rd_narrow;
    logic [WAW-1:0] unissued;
    logic [WAW-1:0] avail;
    logic [2:0]     occ_after;

`ifdef ASYM_FIFO_FLUSH_EN
    typedef enum logic {ST_RUN = 1'b0, ST_PAD = 1'b1} state_t;

    localparam logic [WAW-1:0] LANE_MASK = WAW'(RATIO - 1);

    state_t state_q, state_d;
    logic   flush_done_q, flush_done_d;
    logic   flush_pend_q, flush_pend_d;
    logic   flush_req;
    logic   aligned_next;
`endif

    // Write side: accept narrow words while not full and not padding.
    always_comb begin
        has_space = (level_q < DEPTH_L);
`ifdef ASYM_FIFO_FLUSH_EN
        in_run = (state_q == ST_RUN);
        pad_wr = !rst && (state_q == ST_PAD) && has_space;
`else
        in_run = 1'b1;
        pad_wr = 1'b0;
`endif
        s_ready = !rst && has_space && in_run;
        wr_en   = s_valid && s_ready;
        ram_wce = wr_en || pad_wr;
        ram_wa  = wptr_q;
        ram_wd  = pad_wr ? '0 : s_data;
        wptr_d  = ram_wce ? (wptr_q + WAW'(1)) : wptr_q;
    end

    // Read side: issue a wide read when a full group is stored and the buffer
    // will still have room for the returning word.
    always_comb begin
        m_valid   = !rst && (buf_cnt_q != 2'd0);
        m_data    = buf0_q;
        pop       = m_valid && m_ready;
        rd_narrow = WAW'(rptr_q) << LOG2R;
        unissued  = wptr_q - rd_narrow;
        avail     = unissued >> LOG2R;
        occ_after = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = !rst && (avail != '0) && (occ_after < 3'd2);
        ram_rce   = issue;
        ram_ra    = rptr_q;
        rptr_d    = issue ? (rptr_q + RAW'(1)) : rptr_q;
        inflight_d = issue;
    end

    // Occupancy: +1 per narrow write, -RATIO per wide pop.
    always_comb begin
        level_d = level_q;
        if (ram_wce) begin
            level_d = level_d + (WAW+1)'(1);
        end
        if (pop) begin
            level_d = level_d - (WAW+1)'(RATIO);
        end
        level = level_q;
    end

    // Two-entry output buffer: returning RAM data enters behind the head.
    always_comb begin
        buf_cnt_d = buf_cnt_q;
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        case ({inflight_q, pop})
            2'b01: begin
                buf0_d    = buf1_q;
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b10: begin
                if (buf_cnt_q == 2'd0) begin
                    buf0_d = ram_rq;
                end else begin
                    buf1_d = ram_rq;
                end
                buf_cnt_d = buf_cnt_q + 2'd1;
            end
            2'b11: begin
                if (buf_cnt_q == 2'd1) begin
                    buf0_d = ram_rq;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = ram_rq;
                end
            end
            default: begin
            end
        endcase
    end

`ifdef ASYM_FIFO_FLUSH_EN
    // Flush FSM: pad zero words until the write pointer sits on a group boundary.
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        flush_pend_d = flush_pend_q;
        flush_req    = flush || flush_pend_q;
        aligned_next = ((wptr_d & LANE_MASK) == '0);
        case (state_q)
            ST_RUN: begin
                if (flush_req) begin
                    if (aligned_next) begin
                        flush_done_d = 1'b1;
                        flush_pend_d = 1'b0;
                    end else if (has_space) begin
                        state_d      = ST_PAD;
                        flush_pend_d = 1'b0;
                    end else begin
                        flush_pend_d = 1'b1;
                    end
                end
            end
            ST_PAD: begin
                if (pad_wr && aligned_next) begin
                    state_d      = ST_RUN;
                    flush_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        flush_done = flush_done_q && !rst;
    end

    // Flush FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            flush_done_q <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_done_q <= flush_done_d;
            flush_pend_q <= flush_pend_d;
        end
    end
`endif

    // Pointer, occupancy and buffer registers; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            inflight_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            inflight_q <= inflight_d;
            buf_cnt_q  <= buf_cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

endmodule

// File: tb/tb_asym_bram_fifo_ctrl.sv
// tb_asym_bram_fifo_ctrl
// Directed bench for asym_bram_fifo_ctrl with RATIO = 2 (16-bit in, 32-bit out)
// and a behavioural BRAM. Expected wide words are built from the narrow words
// accepted on s_*; the flush case runs when ASYM_FIFO_FLUSH_EN is defined.
module tb_asym_bram_fifo_ctrl;

    localparam int WDW   = 16;
    localparam int RDW   = 32;
    localparam int WAW   = 11;
    localparam int RAW   = 10;
    localparam int RATIO = RDW / WDW;

    // Clock / reset
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic           s_valid;
    logic           s_ready;
    logic [WDW-1:0] s_data;
    logic           m_valid;
    logic           m_ready;
    logic [RDW-1:0] m_data;
    logic [WAW:0]   level;
    logic           ram_wce;
    logic [WAW-1:0] ram_wa;
    logic [WDW-1:0] ram_wd;
    logic           ram_rce;
    logic [RAW-1:0] ram_ra;
    logic [RDW-1:0] ram_rq;
`ifdef ASYM_FIFO_FLUSH_EN
    logic           flush;
    logic           flush_done;
`endif

    asym_bram_fifo_ctrl #(
        .WRITE_DATA_WIDTH (WDW),
        .READ_DATA_WIDTH  (RDW),
        .WRITE_ADDR_WIDTH (WAW),
        .READ_ADDR_WIDTH  (RAW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .level      (level),
        .ram_wce    (ram_wce),
        .ram_wa     (ram_wa),
        .ram_wd     (ram_wd),
        .ram_rce    (ram_rce),
        .ram_ra     (ram_ra),
        .ram_rq     (ram_rq)
`ifdef ASYM_FIFO_FLUSH_EN
        ,
        .flush      (flush),
        .flush_done (flush_done)
`endif
    );

    // Behavioural BRAM: narrow write port, wide registered read, lane 0 in LSBs.
    logic [WDW-1:0] mem [0:(1<<WAW)-1];
    always @(posedge clk) begin
        if (ram_wce) mem[ram_wa] <= ram_wd;
        if (ram_rce) ram_rq <= {mem[{ram_ra, 1'b1}], mem[{ram_ra, 1'b0}]};
    end

    // Scoreboard
    logic [RDW-1:0] exp_q[$];
    logic           part_v;
    logic [WDW-1:0] part_w;
    int             lvl_model;
    int             n_checks;
    int             n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: track accepted writes, check every visible head, retire pops.
    always @(negedge clk) begin
        if (!rst) begin
            if (s_valid && s_ready) begin
                lvl_model++;
                if (part_v) begin
                    exp_q.push_back({s_data, part_w});
                    part_v = 1'b0;
                end else begin
                    part_w = s_data;
                    part_v = 1'b1;
                end
            end
            if (m_valid) begin
                if (exp_q.size() == 0) check("m_valid_unexpected", {31'd0, m_valid}, 32'd0);
                else                   check("m_data_head", m_data, exp_q[0]);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                lvl_model -= RATIO;
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [WDW-1:0] d);
        logic done;
        done    = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (s_ready) done = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        if (!done) check("push_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_drain(input string tag);
        for (int t = 0; t < 4000 && exp_q.size() != 0; t++) tick();
        check(tag, exp_q.size(), 32'd0);
        repeat (3) tick();
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int pops;
    int wr;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        part_v    = 1'b0;
        part_w    = '0;
        lvl_model = 0;
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b0;
`ifdef ASYM_FIFO_FLUSH_EN
        flush     = 1'b0;
`endif

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_ram_wce", {31'd0, ram_wce}, 32'd0);
        check("rst_ram_rce", {31'd0, ram_rce}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_level", level, 32'd0);
        check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
        check("post_rst_m_valid", {31'd0, m_valid}, 32'd0);
        tick();

        // Test 1: four narrow words -> two wide words
        for (int a = 0; a < 4; a++) push_word(16'h5000 | 16'(a));
        repeat (6) tick();
        @(negedge clk);
        check("t1_m_valid", {31'd0, m_valid}, 32'd1);
        check("t1_level4", level, 32'd4);
        check("t1_word0", m_data, 32'h50015000);
        tick();
        m_ready = 1'b1;
        @(negedge clk);
        check("t1_pop0", m_data, 32'h50015000);
        tick();
        @(negedge clk);
        check("t1_pop1", m_data, 32'h50035002);
        tick();
        m_ready = 1'b0;
        @(negedge clk);
        check("t1_level0", level, 32'd0);
        check("t1_empty", {31'd0, m_valid}, 32'd0);
        tick();

        // Test 2: fill to 2048, pop one group, refill, drain across the wrap
        for (int i = 0; i < (1 << WAW); i++) push_word(16'(i));
        s_valid = 1'b1;
        s_data  = 16'hBEEF;
        @(negedge clk);
        check("t2_full_s_ready", {31'd0, s_ready}, 32'd0);
        check("t2_full_level", level, 32'd2048);
        tick();
        m_ready = 1'b1;
        @(negedge clk);
        check("t2_pop_same_cycle", {31'd0, s_ready}, 32'd0);
        tick();
        m_ready = 1'b0;
        @(negedge clk);
        check("t2_ready_after_pop", {31'd0, s_ready}, 32'd1);
        check("t2_level_after_pop", level, 32'd2046);
        tick();
        s_data = 16'hBEF0;
        @(negedge clk);
        check("t2_ready_2047", {31'd0, s_ready}, 32'd1);
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        check("t2_refull", {31'd0, s_ready}, 32'd0);
        check("t2_refull_level", level, 32'd2048);
        tick();
        m_ready = 1'b1;
        wait_drain("t2_drain");
        m_ready = 1'b0;
        @(negedge clk);
        check("t2_level_end", level, 32'd0);
        check("t2_level_model", level, 32'(lvl_model));
        tick();

        // Test 3: backlog + continuous writes -> one wide word per cycle
        for (int i = 0; i < 40; i++) push_word(16'h3000 + 16'(i));
        repeat (4) tick();
        m_ready = 1'b1;
        pops = 0;
        wr   = 40;
        for (int c = 0; c < 30; c++) begin
            s_valid = 1'b1;
            s_data  = 16'h3000 + 16'(wr);
            wr++;
            @(negedge clk);
            if (c < 10 && m_valid) pops++;
            tick();
        end
        s_valid = 1'b0;
        check("t3_throughput", pops, 32'd10);
        wait_drain("t3_drain");
        check("t3_level_end", level, 32'd0);

        // Test 4: m_ready toggling every cycle while writing
        for (int c = 0; c < 40; c++) begin
            m_ready = (c % 2) == 1;
            s_valid = (c < 12);
            s_data  = 16'h4000 + 16'(c);
            @(negedge clk);
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        wait_drain("t4_drain");
        check("t4_level_end", level, 32'd0);
        m_ready = 1'b0;

        // Test 5: reset with buffered data and a read in flight
        for (int i = 0; i < 5; i++) push_word(16'h6000 + 16'(i));
        rst = 1'b1;
        exp_q.delete();
        part_v    = 1'b0;
        lvl_model = 0;
        @(negedge clk);
        check("t5_rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("t5_rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("t5_rst_ram_rce", {31'd0, ram_rce}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_level", level, 32'd0);
        check("t5_m_valid", {31'd0, m_valid}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            check("t5_no_stale", {31'd0, m_valid}, 32'd0);
        end
        tick();
        push_word(16'h7000);
        push_word(16'h7001);
        repeat (4) tick();
        @(negedge clk);
        check("t5_fresh_valid", {31'd0, m_valid}, 32'd1);
        check("t5_fresh_first", m_data, 32'h70017000);
        tick();
        m_ready = 1'b1;
        wait_drain("t5_drain");
        check("t5_level_end", level, 32'd0);

`ifdef ASYM_FIFO_FLUSH_EN
        // Test 6: flush a partial group (one zero pad), then an aligned flush
        push_word(16'h8000);
        push_word(16'h8001);
        push_word(16'h8002);
        flush = 1'b1;
        exp_q.push_back({16'h0000, part_w});
        part_v    = 1'b0;
        lvl_model = lvl_model + 1;
        @(negedge clk);
        check("t6_done_early", {31'd0, flush_done}, 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("t6_pad_s_ready", {31'd0, s_ready}, 32'd0);
        check("t6_pad_wce", {31'd0, ram_wce}, 32'd1);
        check("t6_pad_wd", {16'd0, ram_wd}, 32'd0);
        tick();
        @(negedge clk);
        check("t6_flush_done", {31'd0, flush_done}, 32'd1);
        tick();
        @(negedge clk);
        check("t6_done_pulse", {31'd0, flush_done}, 32'd0);
        tick();
        wait_drain("t6_drain");
        check("t6_level_end", level, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("t6_aligned_done", {31'd0, flush_done}, 32'd1);
        tick();
`endif

        m_ready = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
